burst_ram_arbiter: RTL and testbench

//  Shares one burst RAM (PSRAM IP or its simulation emulator) between two requesters, e.g. I-cache (port 0) and D-cache (port 1).

---
 rtl/burst_ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin arbiter for a shared burst RAM: one full read or write burst per grant,
// with write-data streaming, read-data steering and a sticky read-timeout watchdog.
module burst_ram_arbiter #(
    parameter int DataBitWidth      = 64,
    parameter int AddressBitWidth   = 4,
    parameter int BurstDataCount    = 4,
    parameter int ReadTimeoutCycles = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        m0_req,
    input  logic                        m0_cmd,
    input  logic [AddressBitWidth-1:0]  m0_addr,
    input  logic [DataBitWidth-1:0]     m0_wr_data,
    output logic                        m0_wr_taken,
    output logic [DataBitWidth-1:0]     m0_rd_data,
    output logic                        m0_rd_data_valid,
    output logic                        m0_grant,
    output logic                        m0_done,

    input  logic                        m1_req,
    input  logic                        m1_cmd,
    input  logic [AddressBitWidth-1:0]  m1_addr,
    input  logic [DataBitWidth-1:0]     m1_wr_data,
    output logic                        m1_wr_taken,
    output logic [DataBitWidth-1:0]     m1_rd_data,
    output logic                        m1_rd_data_valid,
    output logic                        m1_grant,
    output logic                        m1_done,

    output logic                        ram_cmd,
    output logic                        ram_cmd_en,
    output logic [AddressBitWidth-1:0]  ram_addr,
    output logic [DataBitWidth-1:0]     ram_wr_data,
    output logic [DataBitWidth/8-1:0]   ram_data_mask,
    input  logic [DataBitWidth-1:0]     ram_rd_data,
    input  logic                        ram_rd_data_valid,
    input  logic                        ram_init_calib,
    input  logic                        ram_busy,

    output logic                        ready,
    output logic                        error
);

    localparam int WCW = $clog2(BurstDataCount) + 1;
    localparam int TCW = $clog2(ReadTimeoutCycles) + 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(BurstDataCount - 1);
    localparam logic [TCW-1:0] LAST_TICK = TCW'(ReadTimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                       owner;
    logic                       last_grant;
    logic                       issue;
    logic                       cmd_q;
    logic [AddressBitWidth-1:0] addr_q;
    logic                       error_q;
    logic [WCW-1:0]             word_cnt;
    logic [TCW-1:0]             tick_cnt;

    logic                       pick;
    logic                       start;
    logic                       sel_cmd;
    logic [AddressBitWidth-1:0] sel_addr;
    logic                       rd_valid_own;
    logic                       last_rd_word;
    logic                       timeout;
    logic                       bursting;

    // Request selection and burst progress decode
    always_comb begin
        pick         = (m0_req && m1_req) ? ~last_grant : m1_req;
        start        = (state == S_IDLE) && !ram_busy && (m0_req || m1_req);
        sel_cmd      = pick ? m1_cmd  : m0_cmd;
        sel_addr     = pick ? m1_addr : m0_addr;
        rd_valid_own = (state == S_READ) && ram_rd_data_valid;
        last_rd_word = rd_valid_own && (word_cnt == LAST_WORD);
        timeout      = (state == S_READ) && (tick_cnt == LAST_TICK) && !last_rd_word;
        bursting     = (state == S_WRITE) || (state == S_READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (ram_init_calib) state_nxt = S_IDLE;
            S_IDLE:  if (start) state_nxt = sel_cmd ? S_WRITE : S_READ;
            S_WRITE: if (word_cnt == LAST_WORD) state_nxt = S_DONE;
            S_READ:  if (last_rd_word || timeout) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // last_grant resets to port 1 so that port 0 wins the first contested arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            issue      <= 1'b0;
            cmd_q      <= 1'b0;
            addr_q     <= '0;
            word_cnt   <= '0;
            tick_cnt   <= '0;
            error_q    <= 1'b0;
        end else begin
            issue <= start;
            if (start) begin
                owner      <= pick;
                last_grant <= pick;
                cmd_q      <= sel_cmd;
                addr_q     <= sel_addr;
                word_cnt   <= '0;
                tick_cnt   <= '0;
            end else begin
                if ((state == S_WRITE) || rd_valid_own) begin
                    word_cnt <= word_cnt + 1'b1;
                end
                if (state == S_READ) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
                if (timeout) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        m0_grant         = bursting && !owner;
        m1_grant         = bursting &&  owner;
        m0_done          = (state == S_DONE) && !owner;
        m1_done          = (state == S_DONE) &&  owner;
        m0_wr_taken      = (state == S_WRITE) && !owner;
        m1_wr_taken      = (state == S_WRITE) &&  owner;
        m0_rd_data_valid = rd_valid_own && !owner;
        m1_rd_data_valid = rd_valid_own &&  owner;
        m0_rd_data       = ram_rd_data;
        m1_rd_data       = ram_rd_data;
        ram_cmd          = cmd_q;
        ram_cmd_en       = issue;
        ram_addr         = addr_q;
        ram_wr_data      = owner ? m1_wr_data : m0_wr_data;
        ram_data_mask    = '0;
        ready            = (state != S_INIT);
        error            = error_q;
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter with a small behavioural burst RAM emulator.
module tb_burst_ram_arbiter;

    localparam int DW     = 64;
    localparam int AW     = 4;
    localparam int BDC    = 4;
    localparam int RTC    = 64;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    req;
    logic [1:0]    cmd;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    wire  [1:0]    taken, rvalid, grant, done;
    wire  [DW-1:0] rdata0, rdata1;

    wire           ram_cmd, ram_cmd_en;
    wire  [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_wr_data;
    wire  [DW/8-1:0] ram_data_mask;
    logic [DW-1:0] ram_rd_data = '0;
    logic          ram_rd_data_valid = 1'b0;
    logic          ram_init_calib;
    wire           ram_busy;
    wire           ready, error;

    burst_ram_arbiter #(
        .DataBitWidth(DW), .AddressBitWidth(AW),
        .BurstDataCount(BDC), .ReadTimeoutCycles(RTC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(req[0]), .m0_cmd(cmd[0]), .m0_addr(addr[0]), .m0_wr_data(wdata[0]),
        .m0_wr_taken(taken[0]), .m0_rd_data(rdata0), .m0_rd_data_valid(rvalid[0]),
        .m0_grant(grant[0]), .m0_done(done[0]),
        .m1_req(req[1]), .m1_cmd(cmd[1]), .m1_addr(addr[1]), .m1_wr_data(wdata[1]),
        .m1_wr_taken(taken[1]), .m1_rd_data(rdata1), .m1_rd_data_valid(rvalid[1]),
        .m1_grant(grant[1]), .m1_done(done[1]),
        .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
        .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
        .ram_init_calib(ram_init_calib), .ram_busy(ram_busy),
        .ready(ready), .error(error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] default_word(input int i);
        return 64'hD000_0000_0000_0000 | DW'(i);
    endfunction

    // ---------------- RAM emulator ----------------
    logic [DW-1:0] mem [16];
    logic [15:0]   written = '0;
    logic          m_active = 1'b0;
    logic          m_rd = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            m_cnt = 0;
    int            m_lat = 0;
    int            rd_lat = RD_LAT;
    assign ram_busy = m_active;

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        return written[a] ? mem[a] : default_word(int'(a));
    endfunction

    always @(posedge clk) begin
        ram_rd_data_valid <= 1'b0;
        if (!m_active) begin
            if (ram_cmd_en) begin
                m_active <= 1'b1;
                m_rd     <= !ram_cmd;
                m_addr   <= ram_addr;
                m_lat    <= 0;
                if (ram_cmd) begin
                    mem[ram_addr]     <= ram_wr_data;
                    written[ram_addr] <= 1'b1;
                    m_cnt             <= 1;
                end else begin
                    m_cnt <= 0;
                end
            end
        end else if (!m_rd) begin
            mem[4'(m_addr + m_cnt)]     <= ram_wr_data;
            written[4'(m_addr + m_cnt)] <= 1'b1;
            m_cnt <= m_cnt + 1;
            if (m_cnt == BDC - 1) m_active <= 1'b0;
        end else if (m_lat < rd_lat) begin
            m_lat <= m_lat + 1;
        end else begin
            ram_rd_data       <= rd_word(4'(m_addr + m_cnt));
            ram_rd_data_valid <= 1'b1;
            m_cnt <= m_cnt + 1;
            if (m_cnt == BDC - 1) m_active <= 1'b0;
        end
    end

    // ---------------- scoreboard / monitors ----------------
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] wbuf [2][BDC];
    logic [DW-1:0] exp_rd0 [$];
    logic [DW-1:0] exp_rd1 [$];
    int            exp_grant [$];
    int            cyc = 0;
    int            cmd_en_cnt = 0;
    int            cmd_en_cyc = 0;
    int            last_done_cyc = 0;
    logic [1:0]    grant_q = '0;

    always @(negedge clk) begin
        int exp_p;
        logic [DW-1:0] exp_d;
        cyc++;
        if (ram_cmd_en) begin
            cmd_en_cnt++;
            cmd_en_cyc = cyc;
        end
        if (done != 2'b00) last_done_cyc = cyc;
        if (rvalid[0]) begin
            exp_d = (exp_rd0.size() != 0) ? exp_rd0.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            check("rd_data_m0", rdata0, exp_d);
        end
        if (rvalid[1]) begin
            exp_d = (exp_rd1.size() != 0) ? exp_rd1.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
            check("rd_data_m1", rdata1, exp_d);
        end
        if (grant != 2'b00) check("grant_exclusive", 64'(grant == 2'b11), 0);
        for (int p = 0; p < 2; p++) begin
            if (grant[p] && !grant_q[p]) begin
                exp_p = (exp_grant.size() != 0) ? exp_grant.pop_front() : -1;
                check("grant_order", 64'(p), 64'(exp_p));
            end
            if (done[p]) begin
                check("done_after_grant", 64'(grant_q[p]), 1);
                check("done_grant_low", 64'(grant[p]), 0);
            end
        end
        grant_q = grant;
    end

    // One burst from port p; returns at the negedge of its done cycle (or on budget expiry).
    task automatic burst(input int p, input bit wr, input logic [AW-1:0] a,
                         input bit hold, input bit exp_data);
        bit t, fin;
        int n_taken, n, widx;
        cmd[p]   = wr;
        addr[p]  = a;
        wdata[p] = wbuf[p][0];
        for (int i = 0; i < BDC; i++) begin
            if (wr) ref_mem[4'(a + i)] = wbuf[p][i];
            else if (exp_data) begin
                if (p == 0) exp_rd0.push_back(ref_mem[4'(a + i)]);
                else        exp_rd1.push_back(ref_mem[4'(a + i)]);
            end
        end
        req[p] = 1'b1;
        t = 1'b0; fin = 1'b0; n_taken = 0; n = 0; widx = 0;
        while (!fin && n < 300) begin
            @(posedge clk);
            #1;
            if (t && widx < BDC - 1) begin
                widx++;
                wdata[p] = wbuf[p][widx];
            end
            @(negedge clk);
            n++;
            t = taken[p];
            if (t) n_taken++;
            fin = done[p];
        end
        if (!hold) req[p] = 1'b0;
        check("done_seen", 64'(fin), 1);
        if (wr) check("wr_taken_count", 64'(n_taken), BDC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) ref_mem[i] = default_word(i);
        req = '0; cmd = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        ram_init_calib = 1'b0;

        // 1: reset state and init handshake
        repeat (3) @(negedge clk);
        check("reset_outputs", {grant, done, taken, rvalid, ram_cmd_en, ram_cmd, ram_addr, ready, error}, 0);
        check("data_mask", 64'(ram_data_mask), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("ready_before_calib", 64'(ready), 0);
        check("cmd_en_before_calib", 64'(cmd_en_cnt), 0);
        ram_init_calib = 1'b1;
        @(negedge clk); #1;
        check("ready_after_calib", 64'(ready), 1);

        // 2: write then read back on port 0
        wbuf[0] = '{64'h11, 64'h22, 64'h33, 64'h44};
        @(negedge clk);
        exp_grant.push_back(0); exp_grant.push_back(0);
        burst(0, 1'b1, 4'd4, 1'b0, 1'b1);
        burst(0, 1'b0, 4'd4, 1'b0, 1'b1);
        #1;
        check("error_after_read", 64'(error), 0);

        // 3: simultaneous reads right after reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            burst(0, 1'b0, 4'd4,  1'b0, 1'b1);
            burst(1, 1'b0, 4'd12, 1'b0, 1'b1);
        join

        // 4: both hold requests across four bursts
        wbuf[0] = '{64'hA1, 64'hB2, 64'hC3, 64'hD4};
        @(negedge clk);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(0); exp_grant.push_back(1);
        fork
            begin
                burst(0, 1'b1, 4'd0, 1'b1, 1'b1);
                burst(0, 1'b0, 4'd0, 1'b0, 1'b1);
            end
            begin
                burst(1, 1'b0, 4'd12, 1'b1, 1'b1);
                burst(1, 1'b0, 4'd8,  1'b0, 1'b1);
            end
        join

        // 5: read timeout, late words must be dropped, then a normal read
        rd_lat = 70;
        @(negedge clk);
        exp_grant.push_back(0);
        burst(0, 1'b0, 4'd8, 1'b0, 1'b0);
        #1;
        check("timeout_latency", 64'(last_done_cyc - cmd_en_cyc), RTC);
        check("error_on_timeout", 64'(error), 1);
        rd_lat = RD_LAT;
        exp_grant.push_back(1);
        burst(1, 1'b0, 4'd4, 1'b0, 1'b1);
        #1;
        check("error_sticky", 64'(error), 1);

        // 6: reset asserted in the middle of a write burst
        wbuf[0] = '{64'h5A5A, 64'h6B6B, 64'h7C7C, 64'h8D8D};
        @(negedge clk);
        exp_grant.push_back(0);
        cmd[0] = 1'b1; addr[0] = 4'd8; wdata[0] = wbuf[0][0]; req[0] = 1'b1;
        n = 0;
        while (!grant[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_write_grant", 64'(grant[0]), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {grant, done, taken, rvalid, ram_cmd_en, ram_cmd, ram_addr, ready, error}, 0);
        req[0] = 1'b0;
        ram_init_calib = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reinit_wait_calib", 64'(ready), 0);
        ram_init_calib = 1'b1;
        @(negedge clk); #1;
        check("reinit_ready", 64'(ready), 1);
        wbuf[0] = '{64'h1111_0000, 64'h2222_0000, 64'h3333_0000, 64'h4444_0000};
        exp_grant.push_back(0); exp_grant.push_back(0);
        burst(0, 1'b1, 4'd8, 1'b0, 1'b1);
        burst(0, 1'b0, 4'd8, 1'b0, 1'b1);

        repeat (5) @(negedge clk);
        #1;
        check("rd_queue_m0_empty", 64'(exp_rd0.size()), 0);
        check("rd_queue_m1_empty", 64'(exp_rd1.size()), 0);
        check("grant_queue_empty", 64'(exp_grant.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
